// File: rtl/uart_tx_engine_pkg.sv
// Shared definitions for the UART transmit path: FSM encoding, frame length
// and the frame layout helper.
package uart_tx_engine_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2
  } tx_state_t;

  localparam int FRAME_BITS = 11;
  localparam logic [10:0] IDLE_FRAME = 11'h7FF;

  // Bit 0 is the leading idle bit, bit 1 the start bit, then d0..d6, b9, b10.
  function automatic logic [10:0] build_frame(input logic [1:0] dec_bits,
                                              input logic [7:0] data);
    return {dec_bits[1], dec_bits[0], data[6:0], 1'b0, 1'b1};
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-time counter: pulses btu once every k enabled cycles; clr restarts the count.
module uart_bit_timer #(
  parameter int BAUD_W = 19
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              clr,
  input  logic [BAUD_W-1:0] k,
  output logic              btu
);

  logic [BAUD_W-1:0] baud_cnt_reg;

  // k is never zero here; the engine substitutes 1 when the baud count is 0.
  assign btu = en && (baud_cnt_reg == (k - BAUD_W'(1)));

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      baud_cnt_reg <= '0;
    end else if (en) begin
      baud_cnt_reg <= btu ? '0 : baud_cnt_reg + BAUD_W'(1);
    end
  end

endmodule

// File: rtl/uart_tx_engine.sv
// UART transmit engine: captures a byte, frames it with decoder-supplied upper
// bits and shifts the 11-bit frame out on tx, LSB first, one bit per k cycles.
module uart_tx_engine
  import uart_tx_engine_pkg::*;
#(
  parameter int BAUD_W = 19,
  parameter int NBITS  = FRAME_BITS
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [7:0]        din,
  input  logic [1:0]        dec_bits,
  input  logic [BAUD_W-1:0] baud_k,
  output logic [7:0]        data_q,
  output logic              tx,
  output logic              txrdy
);

  tx_state_t         state_reg;
  logic [10:0]       sr_reg;
  logic [7:0]        data_reg;
  logic              txrdy_reg;
  logic [3:0]        bit_cnt_reg;
  logic [BAUD_W-1:0] k_reg;
  logic              btu;
  logic              timer_en;
  logic              timer_clr;

  assign timer_en  = (state_reg == SHIFT);
  assign timer_clr = (state_reg != SHIFT);

  uart_bit_timer #(
    .BAUD_W(BAUD_W)
  ) u_bit_timer (
    .clk  (clk),
    .reset(reset),
    .en   (timer_en),
    .clr  (timer_clr),
    .k    (k_reg),
    .btu  (btu)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= IDLE;
      txrdy_reg   <= 1'b1;
      data_reg    <= 8'h00;
      sr_reg      <= IDLE_FRAME;
      bit_cnt_reg <= 4'd0;
      k_reg       <= BAUD_W'(1);
    end else begin
      case (state_reg)
        IDLE: begin
          if (load) begin
            data_reg  <= din;
            txrdy_reg <= 1'b0;
            state_reg <= LOAD;
          end
        end
        LOAD: begin
          // The decoder has seen the captured byte for a full cycle by now.
          sr_reg      <= build_frame(dec_bits, data_reg);
          k_reg       <= (baud_k == '0) ? BAUD_W'(1) : baud_k;
          bit_cnt_reg <= 4'd0;
          state_reg   <= SHIFT;
        end
        SHIFT: begin
          if (btu) begin
            sr_reg      <= {1'b1, sr_reg[10:1]};
            bit_cnt_reg <= bit_cnt_reg + 4'd1;
            if (bit_cnt_reg == 4'(NBITS - 1)) begin
              state_reg <= IDLE;
              txrdy_reg <= 1'b1;
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign tx     = sr_reg[0];
  assign txrdy  = txrdy_reg;
  assign data_q = data_reg;

endmodule

// File: tb/tb_uart_tx_engine.sv
// Scoreboard bench for uart_tx_engine: per-cycle expected tx/txrdy values are
// queued when a load is accepted and popped as the DUT advances.
module tb_uart_tx_engine;

  localparam int BAUD_W = 19;
  localparam int NB     = 11;

  logic              clk = 1'b0;
  logic              reset;
  logic              load;
  logic [7:0]        din;
  logic [1:0]        dec_bits;
  logic [BAUD_W-1:0] baud_k;
  logic [7:0]        data_q;
  logic              tx;
  logic              txrdy;

  typedef struct packed {
    logic tx;
    logic txrdy;
  } exp_t;

  exp_t exp_q[$];
  int   pass_cnt  = 0;
  int   total_cnt = 0;

  uart_tx_engine #(.BAUD_W(BAUD_W), .NBITS(NB)) dut (
    .clk     (clk),
    .reset   (reset),
    .load    (load),
    .din     (din),
    .dec_bits(dec_bits),
    .baud_k  (baud_k),
    .data_q  (data_q),
    .tx      (tx),
    .txrdy   (txrdy)
  );

  always #5 clk = ~clk;

  // Must be called away from a clock edge. Drives a load, checks acceptance,
  // then checks every cycle of the frame against the queued expectation.
  // busy_at: frame cycle whose edge sees an extra (ignored) load.
  // rst_at:  frame cycle whose edge sees reset; frame aborts there.
  // late:    assert load for the edge where txrdy returns, and leave it held.
  task automatic run_frame(input string name, input logic [7:0] d, input logic [1:0] db,
                           input logic [BAUD_W-1:0] bk, input int busy_at,
                           input int rst_at, input bit late, input logic [7:0] next_d);
    int         kk;
    int         n_last;
    logic [10:0] frame;
    exp_t       e;
    int         errs;
    errs     = 0;
    kk       = (bk == 0) ? 1 : int'(bk);
    n_last   = 1 + NB * kk;
    frame    = {db[1], db[0], d[6:0], 1'b0, 1'b1};
    load     = 1'b1;
    din      = d;
    dec_bits = db;
    baud_k   = bk;
    @(posedge clk);
    #1;
    load = 1'b0;
    din  = ~d;
    total_cnt++;
    if (txrdy !== 1'b0 || data_q !== d) begin
      $display("FAIL %s accept: txrdy=%0b data_q=%02h, expected txrdy=0 data_q=%02h",
               name, txrdy, data_q, d);
      errs++;
    end else pass_cnt++;
    for (int n = 1; n <= n_last; n++) begin
      e.tx    = (n == n_last) ? 1'b1 : frame[(n - 1) / kk];
      e.txrdy = (n == n_last);
      exp_q.push_back(e);
    end
    for (int n = 1; n <= n_last; n++) begin
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      if (n == rst_at) begin
        total_cnt++;
        if (tx !== 1'b1 || txrdy !== 1'b1 || data_q !== 8'h00) begin
          $display("FAIL %s reset_abort: tx=%0b txrdy=%0b data_q=%02h, expected 1 1 00",
                   name, tx, txrdy, data_q);
          errs++;
        end else pass_cnt++;
        reset = 1'b0;
        exp_q.delete();
        break;
      end
      total_cnt++;
      if (tx !== e.tx || txrdy !== e.txrdy) begin
        $display("FAIL %s cycle %0d: tx=%0b txrdy=%0b, expected tx=%0b txrdy=%0b",
                 name, n, tx, txrdy, e.tx, e.txrdy);
        errs++;
      end else pass_cnt++;
      if (n == n_last) begin
        total_cnt++;
        if (data_q !== d) begin
          $display("FAIL %s data_hold: data_q=%02h, expected %02h", name, data_q, d);
          errs++;
        end else pass_cnt++;
      end
      // Baud count changes mid-frame must not disturb the latched bit time.
      if (n == 1) baud_k = bk + BAUD_W'(7);
      dec_bits = ~db;
      load     = (busy_at != 0 && n + 1 == busy_at) || (late && n + 1 >= n_last);
      din      = late ? next_d : 8'hAA;
      reset    = (rst_at != 0 && n + 1 == rst_at);
    end
    $display("frame %s din=%02h dec=%0b k=%0d errors=%0d", name, d, db, kk, errs);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total_cnt++;
    if (tx !== 1'b1 || txrdy !== 1'b1 || data_q !== 8'h00) begin
      $display("FAIL reset_state: tx=%0b txrdy=%0b data_q=%02h, expected 1 1 00",
               tx, txrdy, data_q);
    end else pass_cnt++;
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      total_cnt++;
      if (tx !== 1'b1 || txrdy !== 1'b1 || data_q !== 8'h00) begin
        $display("FAIL reset_hold %0d: tx=%0b txrdy=%0b data_q=%02h, expected 1 1 00",
                 i, tx, txrdy, data_q);
      end else pass_cnt++;
    end
    $display("reset: tx=%0b txrdy=%0b data_q=%02h", tx, txrdy, data_q);
  endtask

  task automatic test_basic_frame();
    run_frame("basic", 8'h55, 2'b10, 19'd4, 0, 0, 1'b0, 8'h00);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_busy_load();
    run_frame("busy", 8'h55, 2'b10, 19'd4, 20, 0, 1'b0, 8'h00);
    repeat (4) @(posedge clk);
    #1;
    total_cnt++;
    if (tx !== 1'b1 || txrdy !== 1'b1 || data_q !== 8'h55) begin
      $display("FAIL busy_single_frame: tx=%0b txrdy=%0b data_q=%02h, expected 1 1 55",
               tx, txrdy, data_q);
    end else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    run_frame("b2b_first", 8'hA7, 2'b11, 19'd3, 0, 0, 1'b1, 8'h12);
    run_frame("b2b_second", 8'h12, 2'b01, 19'd3, 0, 0, 1'b0, 8'h00);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_degenerate_baud();
    run_frame("baud0", 8'hC3, 2'b11, 19'd0, 0, 0, 1'b0, 8'h00);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid_frame();
    // d3 occupies frame bit 5, i.e. cycles 1+5k .. 5k+k with k=5.
    run_frame("rst_mid", 8'h96, 2'b10, 19'd5, 0, 1 + 5 * 5 + 1, 1'b0, 8'h00);
    @(posedge clk);
    #1;
    total_cnt++;
    if (tx !== 1'b1 || txrdy !== 1'b1) begin
      $display("FAIL rst_mid_quiet: tx=%0b txrdy=%0b, expected 1 1", tx, txrdy);
    end else pass_cnt++;
    run_frame("after_rst", 8'h96, 2'b10, 19'd5, 0, 0, 1'b0, 8'h00);
  endtask

  initial begin
    reset    = 1'b1;
    load     = 1'b0;
    din      = 8'h00;
    dec_bits = 2'b11;
    baud_k   = 19'd4;
    test_reset();
    test_basic_frame();
    test_busy_load();
    test_back_to_back();
    test_degenerate_baud();
    test_reset_mid_frame();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/uart_tx_engine.md
Name: uart_tx_engine

Overview:
Serial transmit engine for the UART TX path.
- Captures one byte from the processor write strobe and presents the captured byte to the parity/stop decoder.
- Takes the decoder's two upper frame bits and serialises an 11-bit frame on `tx`, LSB first.
- A bit-time counter driven by a programmable baud count paces each bit.
- Sits between the I/O write decode (upstream) and the TX pin; raises `txrdy` for the interrupt/status logic.

Parameters:
- BAUD_W, 19, width of the baud count input `baud_k`.
- NBITS, 11, number of bit-time units (btu) shifted per frame.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- load  in  1  one-cycle write strobe; accepted only when `txrdy`=1.
- din  in  8  byte to transmit, sampled on accepted `load`.
- dec_bits  in  2  frame bits {b10,b9} from the parity/stop decoder, computed combinationally from `data_q`.
- baud_k  in  BAUD_W  clock cycles per bit time.
- data_q  out  8  registered byte; drives the decoder's data input.
- tx  out  1  serial line, idle high.
- txrdy  out  1  1 = ready for a new byte.

Behaviour:
- Reset, synchronous and active-high:
  - state=IDLE, `txrdy`=1, `data_q`=8'h00.
  - Shift register `sr`=11'h7FF, so `tx`=1.
  - Baud counter and bit counter cleared.
  - Reset mid-frame aborts the frame: `tx`=1 on the next edge, no partial bits afterwards.
- State IDLE:
  - `load`=1 at edge E0: `data_q`<=`din`, `txrdy`<=0, go to LOAD.
  - `load`=0: stay in IDLE.
- State LOAD (exactly one cycle):
  - `sr`<={dec_bits[1], dec_bits[0], data_q[6:0], 1'b0, 1'b1}.
  - Latch `k`<=(`baud_k`==0 ? 1 : `baud_k`).
  - Clear baud counter and bit counter; go to SHIFT.
  - `baud_k` changes during SHIFT have no effect on the current frame.
- State SHIFT:
  - btu = (baud_cnt == k-1). If btu, baud_cnt<=0; otherwise baud_cnt<=baud_cnt+1.
  - On btu: `sr`<={1'b1, sr[10:1]}, bit_cnt<=bit_cnt+1.
  - On the btu that makes bit_cnt==NBITS: go to IDLE and set `txrdy`<=1 on that same edge.
- Output: `tx` = `sr[0]`, registered, no combinational path from inputs.
- Timing relative to accepted load at edge E0:
  - `sr` loaded at E1.
  - Start bit (`tx`=0) appears after edge E0+1+k.
  - Data bits d0..d6, then b9, then b10, each k cycles.
  - `txrdy`=1 after edge E0+1+NBITS*k.
- Line sequence: one leading idle bit time, start, d0..d6, b9, b10, then idle. In 7N mode the decoder supplies 11, giving two stop bits.
- `load` while `txrdy`=0 is ignored; `data_q` and the frame are unaffected.
- `load` on the same edge `txrdy` returns to 1 is ignored; it is accepted on the following cycle.
- Counter widths: baud_cnt is BAUD_W bits, bit_cnt is 4 bits. No wrap occurs within legal operation.

Decomposition:
- Shared uart package holds:
  - state encoding constants IDLE/LOAD/SHIFT;
  - NBITS;
  - the idle frame value 11'h7FF.
- One natural sub-module: `uart_bit_timer`, the baud counter producing the btu pulse with enable and clear.

Test Plan:
- Reset check: assert `reset` for 2 cycles → `tx`=1, `txrdy`=1, `data_q`=00, held with no `load`.
- Basic frame, k=4, din=8'h55, bench drives dec_bits=2'b10:
  - `tx`=0 after edge 5;
  - bits d0..d6 = 1,0,1,0,1,0,1, each 4 cycles;
  - b9=0, b10=1;
  - `txrdy` rises after edge 45.
- Busy load: issue `load` with din=8'hAA mid-frame → `data_q` stays 55, frame bits unchanged, single frame only.
- Back-to-back: `load` on the first cycle `txrdy`=1 → new frame starts, `txrdy` low on next edge, idle gap exactly one bit time before start.
- Degenerate baud: `baud_k`=0 → behaves as k=1, with `tx` changing every cycle after LOAD and `txrdy` after edge 12.
- Reset mid-frame: `reset` during bit d3 → `tx`=1 and `txrdy`=1 next edge; a subsequent load transmits a full, correct frame.
